multicycle_control_unit: RTL

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/riscv_mc_pkg.sv | 43 ++++
 rtl/mc_alu_decoder.sv | 51 +++++
 rtl/multicycle_control_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/riscv_mc_pkg.sv
// Shared definitions for the multicycle RISC-V control unit: FSM state
// encoding, ALU operation classes, ALU control codes and opcode constants.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXECR    = 4'd6,
    ST_EXECI    = 4'd7,
    ST_ALUWB    = 4'd8,
    ST_JAL      = 4'd9,
    ST_BRANCH   = 4'd10
  } state_t;

  // Operation class handed from the FSM to the ALU decoder
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // Full 4-bit ALU control codes; the 3-bit build keeps the low bits
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU control decoder: maps the FSM's operation class plus funct fields to
// an ALU control code. ALU_CTRL_W selects the 3-bit (reduced) or 4-bit
// (full RV32I ALU) code set; only 3 and 4 are meaningful.
module mc_alu_decoder
  import riscv_mc_pkg::*;
#(
  parameter int ALU_CTRL_W = 3
) (
  input  logic [1:0]            alu_op,
  input  logic [2:0]            funct3,
  input  logic                  funct7_5,
  input  logic                  op_5,
  output logic [ALU_CTRL_W-1:0] alu_control
);

  localparam bit WIDE = (ALU_CTRL_W == 4);

  localparam logic [ALU_CTRL_W-1:0] C_ADD  = ALU_ADD[ALU_CTRL_W-1:0];
  localparam logic [ALU_CTRL_W-1:0] C_SUB  = ALU_SUB[ALU_CTRL_W-1:0];
  localparam logic [ALU_CTRL_W-1:0] C_AND  = ALU_AND[ALU_CTRL_W-1:0];
  localparam logic [ALU_CTRL_W-1:0] C_OR   = ALU_OR[ALU_CTRL_W-1:0];
  localparam logic [ALU_CTRL_W-1:0] C_XOR  = ALU_XOR[ALU_CTRL_W-1:0];
  localparam logic [ALU_CTRL_W-1:0] C_SLT  = ALU_SLT[ALU_CTRL_W-1:0];
  localparam logic [ALU_CTRL_W-1:0] C_SLL  = ALU_SLL[ALU_CTRL_W-1:0];
  localparam logic [ALU_CTRL_W-1:0] C_SRL  = ALU_SRL[ALU_CTRL_W-1:0];
  localparam logic [ALU_CTRL_W-1:0] C_SRA  = ALU_SRA[ALU_CTRL_W-1:0];
  localparam logic [ALU_CTRL_W-1:0] C_SLTU = ALU_SLTU[ALU_CTRL_W-1:0];

  // Operations the narrow ALU cannot perform fall back to add
  always_comb begin
    alu_control = C_ADD;
    case (alu_op)
      ALU_OP_SUB: alu_control = C_SUB;
      ALU_OP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op_5 & funct7_5) ? C_SUB : C_ADD;
          3'b010:  alu_control = C_SLT;
          3'b110:  alu_control = C_OR;
          3'b111:  alu_control = C_AND;
          3'b100:  alu_control = WIDE ? C_XOR : C_ADD;
          3'b001:  alu_control = WIDE ? C_SLL : C_ADD;
          3'b011:  alu_control = WIDE ? C_SLTU : C_ADD;
          3'b101:  alu_control = WIDE ? (funct7_5 ? C_SRA : C_SRL) : C_ADD;
          default: alu_control = C_ADD;
        endcase
      end
      default: alu_control = C_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-V control unit: Moore FSM sequencing fetch/decode/execute,
// with combinational imm_src, branch-taken and ALU control decode.
// Optional performance counters (cycle_count, instret_count) are built when
// MC_CTRL_PERF_EN is defined.
module multicycle_control_unit
  import riscv_mc_pkg::*;
#(
  parameter int ALU_CTRL_W = 3,
  parameter int BNE_EN     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  funct7_5,
  input  logic                  zero,
  output logic                  pc_write,
  output logic                  adr_src,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic                  reg_write,
  output logic [1:0]            result_src,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            imm_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  illegal_op,
  output logic [3:0]            state_o
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0]           cycle_count,
  output logic [31:0]           instret_count
`endif
);

  localparam bit BNE_ON = (BNE_EN != 0);

  state_t     state_reg;
  state_t     state_next;
  logic       pc_update;
  logic       branch;
  logic       ir_write_s;
  logic       reg_write_s;
  logic       mem_write_s;
  logic [1:0] alu_op;
  logic       taken;
  logic       branch_supported;
  logic       op_legal;

  // State register; reset returns to FETCH at any point of an instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_FETCH;
    else        state_reg <= state_next;
  end

  // Next-state sequencing
  always_comb begin
    state_next = ST_FETCH;
    case (state_reg)
      ST_FETCH: state_next = ST_DECODE;
      ST_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_next = ST_MEMADR;
          OP_RTYPE:          state_next = ST_EXECR;
          OP_ITYPE:          state_next = ST_EXECI;
          OP_JAL:            state_next = ST_JAL;
          OP_BRANCH:         state_next = ST_BRANCH;
          default:           state_next = ST_FETCH;
        endcase
      end
      ST_MEMADR:  state_next = op[5] ? ST_MEMWRITE : ST_MEMREAD;
      ST_MEMREAD: state_next = ST_MEMWB;
      ST_EXECR, ST_EXECI, ST_JAL: state_next = ST_ALUWB;
      default:    state_next = ST_FETCH;
    endcase
  end

  // Moore outputs decoded from the current state
  always_comb begin
    pc_update   = 1'b0;
    branch      = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    mem_write_s = 1'b0;
    adr_src     = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_op      = ALU_OP_ADD;
    case (state_reg)
      ST_FETCH: begin
        ir_write_s = 1'b1;
        pc_update  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      ST_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      ST_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      ST_MEMREAD: adr_src = 1'b1;
      ST_MEMWB: begin
        result_src  = 2'b01;
        reg_write_s = 1'b1;
      end
      ST_MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_s = 1'b1;
      end
      ST_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = ALU_OP_FUNCT;
      end
      ST_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = ALU_OP_FUNCT;
      end
      ST_ALUWB: reg_write_s = 1'b1;
      ST_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = ALU_OP_SUB;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  // Branch condition and opcode legality straight from the instruction fields
  always_comb begin
    branch_supported = (funct3 == 3'b000) | ((funct3 == 3'b001) & BNE_ON);
    taken = ((funct3 == 3'b000) & zero) | ((funct3 == 3'b001) & BNE_ON & ~zero);
    case (op)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL: op_legal = 1'b1;
      OP_BRANCH: op_legal = branch_supported;
      default:   op_legal = 1'b0;
    endcase
  end

  // Immediate format follows the opcode, independent of state
  always_comb begin
    case (op)
      OP_STORE:  imm_src = 2'b01;
      OP_BRANCH: imm_src = 2'b10;
      OP_JAL:    imm_src = 2'b11;
      default:   imm_src = 2'b00;
    endcase
  end

  // Write strobes are masked while reset is held, since FETCH itself strobes
  assign pc_write   = rst_n & (pc_update | (branch & taken));
  assign ir_write   = rst_n & ir_write_s;
  assign reg_write  = rst_n & reg_write_s;
  assign mem_write  = rst_n & mem_write_s;
  assign illegal_op = rst_n & (state_reg == ST_DECODE) & ~op_legal;
  assign state_o    = state_reg;

  mc_alu_decoder #(
    .ALU_CTRL_W(ALU_CTRL_W)
  ) u_alu_decoder (
    .alu_op     (alu_op),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .op_5       (op[5]),
    .alu_control(alu_control)
  );

`ifdef MC_CTRL_PERF_EN
  logic retire;
  assign retire = (state_reg == ST_MEMWB) | (state_reg == ST_MEMWRITE) |
                  (state_reg == ST_ALUWB) | (state_reg == ST_BRANCH);

  // Free-running cycle counter and retired-instruction counter, both wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count   <= 32'd0;
      instret_count <= 32'd0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
      if (retire) instret_count <= instret_count + 32'd1;
    end
  end
`endif

endmodule
